bn2d_stream: RTL and testbench
==============================

# bn2d_stream

Streaming, multi-channel, fixed-point 2-D batch-normalisation layer with per-channel coefficients programmed at run time and valid/ready handshakes on both data ports. It consumes one feature map (CHANNELS × HEIGHT × WIDTH samples, channel-major) per `start`. It computes y = sat(round(x·scale + offset)) in a 2-stage pipeline at 1 sample/cycle. It sits between the conv layer output stream and the activation/pooling layers in the inference datapath.

## Interface
- DATA_W, 16, signed sample/coefficient width
- FRAC_W, 8, fractional bits of samples and coefficients (Q(DATA_W-FRAC_W).FRAC_W)
- CHANNELS, 4, number of channels (≥1)
- HEIGHT, 4, rows per channel (≥1)
- WIDTH, 4, columns per channel (≥1)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  coefficient write strobe, honoured only in IDLE
- cfg_ch  in  clog2(CHANNELS)  channel to write
- cfg_scale  in  DATA_W  folded weight/sqrt(var), signed Q format
- cfg_offset  in  DATA_W  folded bias − mean·scale, signed Q format
- start  in  1  1-cycle pulse, begins a frame (ignored unless IDLE)
- busy  out  1  high in RUN and FLUSH
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts sample this cycle
- in_data  in  DATA_W  signed input sample
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts output
- out_data  out  DATA_W  signed normalised sample
- out_ch  out  clog2(CHANNELS)  channel index of out_data
- frame_done  out  1  1-cycle pulse, last sample of frame accepted downstream

## Operation
- Coefficient RAM: CHANNELS entries of {scale, offset}. Reset value: scale = 1<<FRAC_W (1.0), offset = 0. A write happens on cfg_we in IDLE. cfg_we outside IDLE is dropped.
- States:
  - IDLE: start → RUN; pixel counter and channel counter cleared.
  - RUN: in_ready = pipeline can advance. Each accepted sample increments the pixel counter (0..HEIGHT·WIDTH−1). On wrap, the channel counter increments. Acceptance of sample CHANNELS·HEIGHT·WIDTH−1 → FLUSH.
  - FLUSH: in_ready = 0. Once the pipeline is empty (last output accepted) → IDLE, with frame_done pulsed in the cycle that last beat is accepted.
- Pipeline advance: advance = !out_valid || out_ready. Each stage holds its data and channel tag when stalled.
- Stage 1: p = in_data × scale[ch], full 2·DATA_W signed.
- Stage 2 computes:
  - s = p + (sign-extended offset <<< FRAC_W) + (1<<(FRAC_W−1)), giving round-half-up.
  - r = s >>> FRAC_W.
  - Saturate r to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - Result goes to out_data/out_ch.
- Intermediate sum width is 2·DATA_W+1 bits. No intermediate wrap is permitted.

## Timing
- Reset values: in_ready 0, out_valid 0, out_data 0, out_ch 0, busy 0, frame_done 0. State IDLE, counters 0, coefficients as above.
- Latency: 2 cycles from accepted input to out_valid with out_ready held high. Throughput is 1 sample/cycle.
- out_data/out_ch stay stable while out_valid && !out_ready.
- in_ready is registered-free combinational from the stage occupancy and out_ready. It is 0 in IDLE and FLUSH.
- start asserted in the same cycle as the final FLUSH handshake is ignored. A new start is accepted only from IDLE.
- cfg_we coincident with start in IDLE: the write completes and applies to the frame.
- rst mid-frame: immediate return to reset values. The partial frame is discarded, frame_done is not pulsed, and coefficients revert to reset values.
- CHANNELS = 1 or HEIGHT·WIDTH = 1: the counters wrap correctly. A frame with a single sample goes RUN → FLUSH after 1 beat.

## Configuration
- BN2D_RELU_EN:
  - Defined: a ReLU is fused after saturation in stage 2. Negative results are output as 0, and latency is unchanged.
  - Undefined: the signed result is passed unmodified.

## Test plan
- Coefficients ch0 scale 0x0200, offset 0x0100; in_data 0x0180 → out_data 0x0400 (2·1.5+1 = 4.0), 2 cycles after acceptance, out_ch 0.
- Saturation: scale 0x0200, in_data 0x7000 → out_data 0x7FFF. Also in_data 0x9000 → 0x8000.
- ReLU: scale 0x0100, offset 0xFE00, in_data 0x0100 → 0xFF00 without BN2D_RELU_EN, 0x0000 with it.
- Frame sequencing: CHANNELS=2, HEIGHT=WIDTH=2, 8 samples streamed.
  - out_ch sequence 0,0,0,0,1,1,1,1.
  - frame_done on the 8th handshake; busy falls next cycle.
  - cfg_we during busy leaves the RAM unchanged.
- Back-pressure: out_ready low for 5 cycles mid-stream with in_valid high.
  - in_ready drops within the same cycle once both stages are full.
  - out_data is held stable.
  - All samples arrive in order, with no loss or duplication.
- Reset mid-frame after 3 samples:
  - All outputs return to reset values.
  - No frame_done is pulsed.
  - A subsequent start plus a full frame completes normally using default coefficients (out_data = in_data).

Source files
------------

// File: rtl/bn2d_stream.sv
// bn2d_stream: streaming per-channel fixed-point batch norm, y = sat(round(x*scale+offset)).
// Optional macro BN2D_RELU_EN fuses a ReLU after saturation in stage 2.
module bn2d_stream #(
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 8,
    parameter int CHANNELS = 4,
    parameter int HEIGHT   = 4,
    parameter int WIDTH    = 4,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DATA_W-1:0] cfg_scale,
    input  logic [DATA_W-1:0] cfg_offset,
    input  logic              start,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              frame_done
);

    localparam int PIX   = HEIGHT * WIDTH;
    localparam int PIX_W = (PIX > 1) ? $clog2(PIX) : 1;
    localparam int DEPTH = 1 << CH_W;
    localparam int P_W   = 2 * DATA_W;
    localparam int SUM_W = 2 * DATA_W + 1;

    localparam logic signed [SUM_W-1:0] RND =
        SUM_W'(1) <<< (FRAC_W - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        $signed({{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        $signed({{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_W-1:0] r_scale  [DEPTH];
    logic [DATA_W-1:0] r_offset [DEPTH];

    logic [PIX_W-1:0] r_pix_cnt;
    logic [CH_W-1:0]  r_ch_cnt;

    logic              r_s1_valid;
    logic [P_W-1:0]    r_s1_p;
    logic [CH_W-1:0]   r_s1_ch;
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_data;
    logic [CH_W-1:0]   r_s2_ch;

    logic                    w_adv;
    logic                    w_in_fire;
    logic                    w_pix_wrap;
    logic                    w_ch_wrap;
    logic                    w_last;
    logic                    w_frame_done;
    logic signed [P_W-1:0]   w_in_ext;
    logic signed [P_W-1:0]   w_scale_ext;
    logic signed [P_W-1:0]   w_prod;
    logic [DATA_W-1:0]       w_off;
    logic signed [SUM_W-1:0] w_off_ext;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_shr;
    logic [DATA_W-1:0]       w_sat;
    logic [DATA_W-1:0]       w_res;

    // Both stages move together; a stalled output freezes the whole pipe.
    assign w_adv     = !r_s2_valid || out_ready;
    assign in_ready  = (r_state == S_RUN) && w_adv;
    assign w_in_fire = in_valid && in_ready;

    assign w_pix_wrap = (r_pix_cnt == PIX_W'(PIX - 1));
    assign w_ch_wrap  = (r_ch_cnt == CH_W'(CHANNELS - 1));
    assign w_last     = w_pix_wrap && w_ch_wrap;

    assign w_in_ext    = {{DATA_W{in_data[DATA_W-1]}}, in_data};
    assign w_scale_ext = {{DATA_W{r_scale[r_ch_cnt][DATA_W-1]}},
                          r_scale[r_ch_cnt]};
    assign w_prod      = w_in_ext * w_scale_ext;

    // Offset is aligned to the product's 2*FRAC_W binary point before adding.
    assign w_off     = r_offset[r_s1_ch];
    assign w_off_ext = {{(SUM_W-DATA_W){w_off[DATA_W-1]}}, w_off};
    assign w_sum     = {r_s1_p[P_W-1], r_s1_p} + (w_off_ext <<< FRAC_W) + RND;
    assign w_shr     = w_sum >>> FRAC_W;

    // Clamp the rescaled sum into the output range, then optional ReLU.
    always_comb begin
        w_sat = w_shr[DATA_W-1:0];
        if (w_shr > SAT_MAX) begin
            w_sat = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (w_shr < SAT_MIN) begin
            w_sat = {1'b1, {(DATA_W-1){1'b0}}};
        end
`ifdef BN2D_RELU_EN
        w_res = w_sat[DATA_W-1] ? '0 : w_sat;
`else
        w_res = w_sat;
`endif
    end

    // Per-channel coefficients; writes are only taken while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_scale[i]  <= DATA_W'(1) << FRAC_W;
                r_offset[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (cfg_we && r_state == S_IDLE && cfg_ch == CH_W'(i)) begin
                    r_scale[i]  <= cfg_scale;
                    r_offset[i] <= cfg_offset;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, busy and the end-of-frame pulse on the final output beat.
    always_comb begin
        w_state_nxt  = r_state;
        w_frame_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_in_fire && w_last) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (r_s2_valid && out_ready && !r_s1_valid) begin
                    w_frame_done = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy       = (r_state != S_IDLE);
    assign frame_done = w_frame_done;

    // Pixel/channel position of the next accepted sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_cnt <= '0;
            r_ch_cnt  <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_pix_cnt <= '0;
                r_ch_cnt  <= '0;
            end
        end else if (w_in_fire) begin
            if (w_pix_wrap) begin
                r_pix_cnt <= '0;
                r_ch_cnt  <= w_ch_wrap ? '0 : r_ch_cnt + 1'b1;
            end else begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
            end
        end
    end

    // Two-stage datapath: multiply, then offset/round/saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_p     <= '0;
            r_s1_ch    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_ch    <= '0;
        end else if (w_adv) begin
            r_s1_valid <= w_in_fire;
            if (w_in_fire) begin
                r_s1_p  <= w_prod;
                r_s1_ch <= r_ch_cnt;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_res;
                r_s2_ch   <= r_s1_ch;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_ch    = r_s2_ch;

endmodule

// File: tb/tb_bn2d_stream.sv
// tb_bn2d_stream: directed bench for bn2d_stream (2 channels of 2x2).
// Scoreboard records handshakes; expectations are hand-computed constants.
`timescale 1ns/1ps
module tb_bn2d_stream;

    localparam int DW = 16;
    localparam int C  = 2;
    localparam int H  = 2;
    localparam int W  = 2;

`ifdef BN2D_RELU_EN
    localparam logic [15:0] NEG_A = 16'h0000;
    localparam logic [15:0] NEG_B = 16'h0000;
`else
    localparam logic [15:0] NEG_A = 16'hFF00;
    localparam logic [15:0] NEG_B = 16'hFD80;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [0:0]    cfg_ch = '0;
    logic [DW-1:0] cfg_scale = '0;
    logic [DW-1:0] cfg_offset = '0;
    logic          start = 1'b0;
    logic          busy;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [0:0]    out_ch;
    logic          frame_done;

    always #5 clk = ~clk;

    bn2d_stream #(
        .DATA_W(DW), .FRAC_W(8), .CHANNELS(C), .HEIGHT(H), .WIDTH(W)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_scale(cfg_scale), .cfg_offset(cfg_offset),
        .start(start), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch),
        .frame_done(frame_done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [15:0] rx_d[$];
    int rx_c[$];
    int rx_t[$];
    int in_t[$];
    int fd_cnt = 0;
    int fd_at = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) in_t.push_back(cyc);
            if (out_valid && out_ready) begin
                rx_d.push_back(out_data);
                rx_c.push_back(int'(out_ch));
                rx_t.push_back(cyc);
            end
            if (frame_done) begin
                fd_cnt++;
                fd_at = rx_d.size();
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic ch, input logic [15:0] sc,
                          input logic [15:0] of);
        cfg_we = 1'b1;
        cfg_ch = ch;
        cfg_scale = sc;
        cfg_offset = of;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d);
        int t;
        in_valid = 1'b1;
        in_data = d;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("send_accept", in_ready, 1'b1);
        tick();
    endtask

    task automatic wait_fd(input int want);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (fd_cnt < want && t < 100);
        chk("frame_done_seen", (fd_cnt >= want), 1'b1);
    endtask

    task automatic wait_rx(input int want);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (rx_d.size() < want && t < 200);
        chk("rx_count_reached", (rx_d.size() >= want), 1'b1);
    endtask

    logic [15:0] vin1 [8] = '{16'h0180, 16'h7000, 16'h9000, 16'h0000,
                              16'h0100, 16'h0300, 16'hFF80, 16'h0280};
    logic [15:0] vex1 [8] = '{16'h0400, 16'h7FFF, 16'h8000, 16'h0100,
                              NEG_A, 16'h0100, NEG_B, 16'h0080};
    logic [15:0] vin4 [8] = '{16'h1234, 16'hFEDC, 16'h7FFF, 16'h8000,
                              16'h0001, 16'hFFFF, 16'h0100, 16'h4321};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rbase;
        int ibase;
        logic [15:0] e;

        // reset state, with in_valid high to show in_ready stays low
        in_valid = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_out_ch", out_ch, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_in_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // frame 1: arithmetic, saturation, ReLU, sequencing
        cfg_wr(1'b0, 16'h0200, 16'h0100);
        cfg_wr(1'b1, 16'h0100, 16'hFE00);
        out_ready = 1'b1;
        rbase = rx_d.size();
        ibase = in_t.size();
        do_start();
        chk("f1_busy", busy, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                cfg_we = 1'b1;
                cfg_ch = 1'b1;
                cfg_scale = 16'h0400;
                cfg_offset = 16'h0000;
            end
            if (i == 4) cfg_we = 1'b0;
            send(vin1[i]);
        end
        @(negedge clk);
        #1;
        chk("flush_in_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        start = 1'b1;
        wait_fd(1);
        chk("fd_busy_high", busy, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        #1;
        chk("busy_fell", busy, 1'b0);
        chk("f1_fd_count", fd_cnt, 1);
        chk("f1_fd_on_8th", fd_at - rbase, 8);
        wait_rx(rbase + 8);
        chk("f1_latency", rx_t[rbase] - in_t[ibase], 2);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("f1_data%0d", i), rx_d[rbase + i], vex1[i]);
            chk($sformatf("f1_ch%0d", i), rx_c[rbase + i], i / 4);
        end

        // frame 2: back-pressure with a continuous input stream
        cfg_wr(1'b0, 16'h0100, 16'h0000);
        cfg_wr(1'b1, 16'h0100, 16'h0100);
        rbase = rx_d.size();
        do_start();
        fork
            begin
                for (int i = 0; i < 8; i++) send(16'((i + 1) * 16'h0010));
                in_valid = 1'b0;
            end
            begin
                wait_rx(rbase + 2);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    #1;
                    chk("bp_in_ready", in_ready, 1'b0);
                    chk("bp_out_valid", out_valid, 1'b1);
                    chk("bp_hold_data", out_data, 16'h0030);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_fd(2);
        wait_rx(rbase + 8);
        repeat (3) tick();
        chk("bp_total", rx_d.size() - rbase, 8);
        for (int i = 0; i < 8; i++) begin
            e = 16'((i + 1) * 16'h0010) + ((i >= 4) ? 16'h0100 : 16'h0000);
            chk($sformatf("bp_data%0d", i), rx_d[rbase + i], e);
            chk($sformatf("bp_ch%0d", i), rx_c[rbase + i], i / 4);
        end

        // frame 3: reset after three samples
        do_start();
        send(16'h0111);
        send(16'h0222);
        send(16'h0333);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rst_in_ready", in_ready, 1'b0);
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_out_data", out_data, 16'h0000);
        chk("mid_rst_out_ch", out_ch, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_frame_done", frame_done, 1'b0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("mid_rst_no_fd", fd_cnt, 2);
        chk("post_rst_busy", busy, 1'b0);

        // frame 4: default coefficients give identity
        rbase = rx_d.size();
        do_start();
        for (int i = 0; i < 8; i++) send(vin4[i]);
        in_valid = 1'b0;
        wait_fd(3);
        wait_rx(rbase + 8);
        chk("f4_fd_on_8th", fd_at - rbase, 8);
        for (int i = 0; i < 8; i++) begin
            e = vin4[i];
`ifdef BN2D_RELU_EN
            if (e[15]) e = 16'h0000;
`endif
            chk($sformatf("f4_data%0d", i), rx_d[rbase + i], e);
            chk($sformatf("f4_ch%0d", i), rx_c[rbase + i], i / 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
